// File: rtl/fpu_result_stage.sv
// fpu_result_stage: registered 2-entry skid buffer behind the FPU arithmetic units; classifies results, keeps sticky class flags and a delivered counter.
// Latency: 1 cycle from accept to out_valid when the buffer is empty; no combinational in-to-out path.
// Backpressure: in_ready is registered (occupancy < 2) and never depends combinationally on out_ready.
// Optional: define FPU_CANON_NAN_EN to replace every NaN input with canonical quiet NaN 32'h7FC00000.
module fpu_result_stage #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_res,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       out_class,
   output logic [3:0]       flags_sticky,
   input  logic             flags_clr,
   output logic [CNT_W-1:0] res_count
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_in_ready;
   logic [31:0]      r_h_res;
   logic [TAG_W-1:0] r_h_tag;
   logic [3:0]       r_h_cls;
   logic [31:0]      r_t_res;
   logic [TAG_W-1:0] r_t_tag;
   logic [3:0]       r_t_cls;
   logic [3:0]       r_flags;
   logic [CNT_W-1:0] r_count;

   logic             w_accept;
   logic             w_deliver;
   logic [7:0]       w_exp;
   logic [22:0]      w_man;
   logic             w_e_max;
   logic             w_e_zero;
   logic             w_m_zero;
   logic [3:0]       w_in_cls;
   logic [31:0]      w_in_res;

   assign out_valid    = (r_state != ST_EMPTY);
   assign in_ready     = r_in_ready;
   assign out_res      = r_h_res;
   assign out_tag      = r_h_tag;
   assign out_class    = r_h_cls;
   assign flags_sticky = r_flags;
   assign res_count    = r_count;

   assign w_accept  = in_valid & r_in_ready;
   assign w_deliver = out_valid & out_ready;

   // Classify the incoming result; sign bit is ignored, at most one bit is set.
   assign w_exp    = in_res[30:23];
   assign w_man    = in_res[22:0];
   assign w_e_max  = (w_exp == 8'hFF);
   assign w_e_zero = (w_exp == 8'h00);
   assign w_m_zero = (w_man == 23'd0);
   assign w_in_cls = {w_e_max & ~w_m_zero, w_e_max & w_m_zero,
                      w_e_zero & w_m_zero, w_e_zero & ~w_m_zero};

`ifdef FPU_CANON_NAN_EN
   // NaNs lose sign and payload; the class bit still records that a NaN arrived.
   assign w_in_res = w_in_cls[3] ? 32'h7FC0_0000 : in_res;
`else
   assign w_in_res = in_res;
`endif

   // Occupancy transitions for the two-entry buffer.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
         ST_ONE: begin
            if (w_accept && !w_deliver)      w_state_nxt = ST_FULL;
            else if (!w_accept && w_deliver) w_state_nxt = ST_EMPTY;
         end
         ST_FULL: if (w_deliver) w_state_nxt = ST_ONE;
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // Occupancy state and registered ready (room for at least one more entry).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

   // Entry storage: head drives out_*, tail holds the second entry while FULL; head holds when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_res <= '0;
         r_h_tag <= '0;
         r_h_cls <= '0;
         r_t_res <= '0;
         r_t_tag <= '0;
         r_t_cls <= '0;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_h_res <= w_in_res;
                  r_h_tag <= in_tag;
                  r_h_cls <= w_in_cls;
               end
            end
            ST_ONE: begin
               if (w_accept && w_deliver) begin
                  r_h_res <= w_in_res;
                  r_h_tag <= in_tag;
                  r_h_cls <= w_in_cls;
               end else if (w_accept) begin
                  r_t_res <= w_in_res;
                  r_t_tag <= in_tag;
                  r_t_cls <= w_in_cls;
               end
            end
            ST_FULL: begin
               if (w_deliver) begin
                  r_h_res <= r_t_res;
                  r_h_tag <= r_t_tag;
                  r_h_cls <= r_t_cls;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky flags: clear first, then OR in the class of the entry delivered this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_flags <= 4'd0;
      else        r_flags <= (flags_clr ? 4'd0 : r_flags) | (w_deliver ? r_h_cls : 4'd0);
   end

   // Delivered-result counter, wraps silently; unaffected by flags_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_count <= '0;
      else if (w_deliver) r_count <= r_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_fpu_result_stage.sv
// Directed bench for fpu_result_stage with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Uses CNT_W=2 so the counter wrap is reachable with a handful of results.
module tb_fpu_result_stage;
   localparam int TAG_W = 4;
   localparam int CNT_W = 2;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_res;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_res;
   logic [TAG_W-1:0] out_tag;
   logic [3:0]       out_class;
   logic [3:0]       flags_sticky;
   logic             flags_clr;
   logic [CNT_W-1:0] res_count;

   int n_checks = 0;
   int n_fail   = 0;

   fpu_result_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
      .out_class(out_class), .flags_sticky(flags_sticky), .flags_clr(flags_clr),
      .res_count(res_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] t);
      in_valid = v;
      in_res   = r;
      in_tag   = t;
   endtask

   logic [31:0] cls_vec [4];
   logic [3:0]  cls_exp [4];

   initial begin
      cls_vec[0] = 32'h7F80_0000; cls_exp[0] = 4'b0100;
      cls_vec[1] = 32'h8000_0000; cls_exp[1] = 4'b0010;
      cls_vec[2] = 32'h0000_0001; cls_exp[2] = 4'b0001;
      cls_vec[3] = 32'h7FC0_0001; cls_exp[3] = 4'b1000;

      rst_n = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
      drive(1'b0, 32'd0, 4'd0);
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_res", out_res, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_out_class", 32'(out_class), 32'd0);
      chk("rst_flags", 32'(flags_sticky), 32'd0);
      chk("rst_count", 32'(res_count), 32'd0);
      rst_n = 1'b1;
      step();

      // single pass-through
      out_ready = 1'b1;
      drive(1'b1, 32'h3F80_0000, 4'd3);
      step();
      drive(1'b0, 32'd0, 4'd0);
      chk("pt_out_valid", 32'(out_valid), 32'd1);
      chk("pt_out_res", out_res, 32'h3F80_0000);
      chk("pt_out_tag", 32'(out_tag), 32'd3);
      chk("pt_out_class", 32'(out_class), 32'd0);
      step();
      chk("pt_count", 32'(res_count), 32'd1);
      chk("pt_drained", 32'(out_valid), 32'd0);

      // backpressure fill, third input held off
      out_ready = 1'b0;
      drive(1'b1, 32'h4000_0000, 4'd1);
      step();
      chk("bp_ready_one", 32'(in_ready), 32'd1);
      drive(1'b1, 32'h4040_0000, 4'd2);
      step();
      chk("bp_ready_full", 32'(in_ready), 32'd0);
      chk("bp_head_full", out_res, 32'h4000_0000);
      drive(1'b1, 32'h4080_0000, 4'd4);
      step();
      chk("bp_held_ready", 32'(in_ready), 32'd0);
      chk("bp_held_head", out_res, 32'h4000_0000);
      chk("bp_held_tag", 32'(out_tag), 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp_second", out_res, 32'h4040_0000);
      chk("bp_second_tag", 32'(out_tag), 32'd2);
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      step();
      drive(1'b0, 32'd0, 4'd0);
      chk("bp_third", out_res, 32'h4080_0000);
      chk("bp_third_tag", 32'(out_tag), 32'd4);
      step();
      chk("bp_drained", 32'(out_valid), 32'd0);
      chk("bp_count_wrap", 32'(res_count), 32'd0);
      chk("bp_flags_normal", 32'(flags_sticky), 32'd0);

      // class coverage, streamed back to back
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, cls_vec[i], 4'(i));
         step();
         chk($sformatf("cls_%0d", i), 32'(out_class), 32'(cls_exp[i]));
         chk($sformatf("cls_res_%0d", i), out_res, cls_vec[i]);
      end
      drive(1'b0, 32'd0, 4'd0);
      step();
      chk("cls_flags_all", 32'(flags_sticky), 32'hF);
      chk("cls_count", 32'(res_count), 32'd0);

      // clear colliding with delivery of an inf
      out_ready = 1'b0;
      drive(1'b1, 32'h7F80_0000, 4'd5);
      step();
      drive(1'b0, 32'd0, 4'd0);
      chk("clr_pre_flags", 32'(flags_sticky), 32'hF);
      flags_clr = 1'b1; out_ready = 1'b1;
      step();
      flags_clr = 1'b0;
      chk("clr_collision", 32'(flags_sticky), 32'b0100);
      chk("clr_count", 32'(res_count), 32'd1);
      flags_clr = 1'b1;
      step();
      flags_clr = 1'b0;
      chk("clr_plain", 32'(flags_sticky), 32'd0);

      // NaN handling
      out_ready = 1'b0;
      drive(1'b1, 32'hFFC1_2345, 4'd6);
      step();
      drive(1'b0, 32'd0, 4'd0);
`ifdef FPU_CANON_NAN_EN
      chk("nan_res", out_res, 32'h7FC0_0000);
`else
      chk("nan_res", out_res, 32'hFFC1_2345);
`endif
      chk("nan_class", 32'(out_class), 32'b1000);
      out_ready = 1'b1;
      step();
      chk("nan_flags", 32'(flags_sticky), 32'b1000);
      chk("nan_count", 32'(res_count), 32'd2);

      // reset while FULL
      out_ready = 1'b0;
      drive(1'b1, 32'h4100_0000, 4'd7);
      step();
      drive(1'b1, 32'h4110_0000, 4'd8);
      step();
      drive(1'b0, 32'd0, 4'd0);
      chk("mr_full", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      chk("mr_in_ready", 32'(in_ready), 32'd1);
      chk("mr_out_res", out_res, 32'd0);
      chk("mr_flags", 32'(flags_sticky), 32'd0);
      chk("mr_count", 32'(res_count), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("mr_still_empty", 32'(out_valid), 32'd0);

      // counter wrap: five deliveries with CNT_W=2
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h3F80_0000 + 32'(i), 4'(i));
         step();
      end
      drive(1'b0, 32'd0, 4'd0);
      chk("wrap_last_res", out_res, 32'h3F80_0004);
      step();
      chk("wrap_count", 32'(res_count), 32'd1);
      chk("wrap_drained", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
